otter_button_intr_port: RTL and testbench
=========================================

# otter_button_intr_port

Memory-mapped input responder for the RISC-V OTTER I/O bus. It synchronizes and debounces raw board buttons, keeps a live level register, and latches each debounced press in a sticky event register that software clears. It drives the MCU `INTR` input from the masked pending events. It sits beside the board wrapper's output-port registers. It supplies read data that the wrapper ORs into the `IOBUS_IN` mux, and it takes writes from the same `IOBUS_ADDR` / `IOBUS_OUT` / `IOBUS_WR` bus.

## Interface
Parameters:
- `NBTN`, 5: number of buttons, 1–32.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required to accept a level change, ≥1.
- `BASE_ADDR`, 32'h11008010: word-aligned base address of the register block.

Ports:
- `CLK`  in  1: the single clock; same clock as the MCU.
- `RST`  in  1: synchronous, active-high reset.
- `BTN_RAW`  in  NBTN: asynchronous raw button inputs.
- `IOBUS_ADDR`  in  32: bus address.
- `IOBUS_OUT`  in  32: write data from the MCU.
- `IOBUS_WR`  in  1: write strobe, one cycle per store.
- `IOBUS_RD_DATA`  out  32: read data, combinational; 0 when `IOBUS_SEL`=0.
- `IOBUS_SEL`  out  1: combinational; 1 when `IOBUS_ADDR` hits one of the three registers.
- `INTR`  out  1: registered level interrupt request to the MCU.

## Operation
- Register map (full 32-bit address compare; bits above NBTN-1 read 0):
  - BASE+0x0 STATE: read-only debounced levels; writes are ignored.
  - BASE+0x4 EVENT: sticky press flags; writing 1 to a bit clears it (W1C).
  - BASE+0x8 MASK: read/write interrupt enables.
- Synchronizer: two flops per button; `s[i]` is the second stage.
- Debouncer, per button, with a counter `cnt[i]` of width $clog2(DEBOUNCE_CYCLES+1):
  - if `s[i]==deb[i]`: `cnt[i]<=0`.
  - else if `cnt[i]==DEBOUNCE_CYCLES-1`: `deb[i]<=s[i]`, `cnt[i]<=0`.
  - else: `cnt[i]<=cnt[i]+1`.
  - Any mismatch interruption restarts the count. The counter never wraps.
- Event logic: a rise is the edge on which `deb[i]` goes 0→1; it sets `EVENT[i]` on that same edge. Releases (1→0) never set an event.
- EVENT update per bit, evaluated each edge:
  - next = (EVENT & ~clr) | rise
  - `clr` = `IOBUS_OUT` when `IOBUS_WR` is high and the address is BASE+4, else 0.
  - When a rise and a clear hit the same bit on the same edge, set wins.
- MASK write: when `IOBUS_WR` is high and the address is BASE+8, `MASK <= IOBUS_OUT[NBTN-1:0]`.
- INTR: `INTR <= |(EVENT & MASK)`, computed from current register values. It is a level signal; it stays high until software clears the events or masks them.
- Writes to STATE or to unmapped addresses have no effect.
- Reset values: sync flops, `deb`, `cnt`, EVENT, MASK and `INTR` all 0.

## Timing
- Raw change sampled at edge k reaches `s` at edge k+1.
- With a stable input, `deb` changes at edge k+1+DEBOUNCE_CYCLES.
- EVENT sets on the same edge as `deb`; `INTR` rises one edge later if the bit is masked in.
- A W1C or MASK write at edge w updates the register at w. `INTR` reflects the change at w+1.
- Reads are combinational on the current address: same-cycle data, no wait states, no read side effects.
- RST asserted on any edge, including mid-debounce, forces every register to its reset value on that edge. No event survives reset. After release, a held button is re-qualified from `cnt`=0 and sets an event once accepted.

## Test plan
All scenarios use NBTN=5, DEBOUNCE_CYCLES=4, BASE_ADDR=32'h11008010.
- Reset: hold RST for 2 cycles -> STATE, EVENT and MASK read 0x0; `INTR`=0; `IOBUS_SEL`=0 at address 0x11008000.
- Clean press: `BTN_RAW`=5'b00001 held -> STATE reads 0x1 exactly 5 edges after the first sampling edge; EVENT reads 0x1; `INTR` stays 0 with MASK=0.
- Bounce rejection: btn2 toggles high for 3 cycles, then low for 1 cycle, repeated 5 times, then held low -> STATE and EVENT remain 0x0 throughout.
- Interrupt flow: write MASK=0x01, then press btn0 -> `INTR`=1 one edge after EVENT sets. Write 0x01 to EVENT -> EVENT reads 0x0 and `INTR`=0 one edge later. Release btn0 -> EVENT stays 0x0.
- Set beats clear: time a W1C of 0x02 to land on the same edge btn1's `deb` rises -> EVENT bit1 reads 1.
- Reset mid-debounce: btn3 high for 2 cycles, then assert RST for 1 cycle, then keep btn3 high -> no event before reset. STATE bit3 goes to 1 five edges after the first post-reset sampling edge, and EVENT=0x08.

Source files
------------

// File: rtl/otter_button_intr_port.sv
// otter_button_intr_port: button input responder for the OTTER I/O bus.
// Synchronizes and debounces raw buttons, exposes the debounced levels,
// latches presses into sticky W1C event flags and raises a level interrupt
// from the masked pending events.
//
// Bus semantics: there is no valid/ready handshake. A store is a single
// cycle with IOBUS_WR high and takes effect on that clock edge. Reads are
// purely combinational on IOBUS_ADDR, with no wait states and no side
// effects. IOBUS_SEL flags an address hit so the wrapper can OR
// IOBUS_RD_DATA into its input mux.
module otter_button_intr_port #(
  parameter int          NBTN            = 5,
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter logic [31:0] BASE_ADDR       = 32'h11008010
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NBTN-1:0] BTN_RAW,
  input  logic [31:0]     IOBUS_ADDR,
  input  logic [31:0]     IOBUS_OUT,
  input  logic            IOBUS_WR,
  output logic [31:0]     IOBUS_RD_DATA,
  output logic            IOBUS_SEL,
  output logic            INTR
);

  localparam int          CW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] ADDR_STATE = BASE_ADDR;
  localparam logic [31:0] ADDR_EVENT = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_MASK  = BASE_ADDR + 32'd8;

  logic [NBTN-1:0] sync1_q;
  logic [NBTN-1:0] sync2_q;
  logic [NBTN-1:0] deb_q;
  logic [NBTN-1:0] deb_d;
  logic [CW-1:0]   cnt_q [NBTN];
  logic [CW-1:0]   cnt_d [NBTN];
  logic [NBTN-1:0] event_q;
  logic [NBTN-1:0] event_d;
  logic [NBTN-1:0] mask_q;
  logic [NBTN-1:0] mask_d;
  logic [NBTN-1:0] clr;
  logic [NBTN-1:0] rise;
  logic            intr_q;
  logic            wr_event;
  logic            wr_mask;
  logic            unused_wdata;

  // Write data bits above NBTN-1 are architecturally ignored.
  assign unused_wdata = ^IOBUS_OUT;

  assign wr_event = IOBUS_WR && (IOBUS_ADDR == ADDR_EVENT);
  assign wr_mask  = IOBUS_WR && (IOBUS_ADDR == ADDR_MASK);

  // Debounce next-state: any mismatch interruption restarts the count, and
  // the counter is cleared on acceptance so it never wraps.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NBTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Event next-state: a rise on the same edge as a W1C clear wins.
  always_comb begin
    clr     = wr_event ? IOBUS_OUT[NBTN-1:0] : '0;
    rise    = deb_d & ~deb_q;
    event_d = (event_q & ~clr) | rise;
    mask_d  = wr_mask ? IOBUS_OUT[NBTN-1:0] : mask_q;
  end

  // State registers; reset clears everything, including in-flight debounce.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      event_q <= '0;
      mask_q  <= '0;
      intr_q  <= 1'b0;
      for (int i = 0; i < NBTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= BTN_RAW;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      event_q <= event_d;
      mask_q  <= mask_d;
      intr_q  <= |(event_q & mask_q);
      for (int i = 0; i < NBTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign INTR = intr_q;

  // Combinational read decode; unused upper bits read as zero.
  always_comb begin
    IOBUS_SEL     = 1'b0;
    IOBUS_RD_DATA = '0;
    if (IOBUS_ADDR == ADDR_STATE) begin
      IOBUS_SEL                = 1'b1;
      IOBUS_RD_DATA[NBTN-1:0]  = deb_q;
    end else if (IOBUS_ADDR == ADDR_EVENT) begin
      IOBUS_SEL                = 1'b1;
      IOBUS_RD_DATA[NBTN-1:0]  = event_q;
    end else if (IOBUS_ADDR == ADDR_MASK) begin
      IOBUS_SEL                = 1'b1;
      IOBUS_RD_DATA[NBTN-1:0]  = mask_q;
    end
  end

endmodule

// File: tb/tb_otter_button_intr_port.sv
// Bench for otter_button_intr_port with NBTN=5, DEBOUNCE_CYCLES=4.
`timescale 1ns/1ps
module tb_otter_button_intr_port;

  localparam int          NBTN = 5;
  localparam int          DEB  = 4;
  localparam logic [31:0] BASE = 32'h11008010;
  localparam logic [31:0] A_ST = BASE;
  localparam logic [31:0] A_EV = BASE + 32'd4;
  localparam logic [31:0] A_MK = BASE + 32'd8;
  localparam int          W    = 32;

  logic            clk;
  logic            rst;
  logic [NBTN-1:0] btn_raw;
  logic [31:0]     iobus_addr;
  logic [31:0]     iobus_out;
  logic            iobus_wr;
  logic [31:0]     iobus_rd_data;
  logic            iobus_sel;
  logic            intr;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  otter_button_intr_port #(
    .NBTN(NBTN),
    .DEBOUNCE_CYCLES(DEB),
    .BASE_ADDR(BASE)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .BTN_RAW(btn_raw),
    .IOBUS_ADDR(iobus_addr),
    .IOBUS_OUT(iobus_out),
    .IOBUS_WR(iobus_wr),
    .IOBUS_RD_DATA(iobus_rd_data),
    .IOBUS_SEL(iobus_sel),
    .INTR(intr)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Push the expected read value, apply the address, pop and compare.
  task automatic exp_read(input string tag, input logic [31:0] addr, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    iobus_addr = addr;
    #1;
    check({tag, "_sel"}, W'(iobus_sel), W'(1));
    check(tag, iobus_rd_data, exp_q.pop_front());
    iobus_addr = 32'h0;
  endtask

  task automatic exp_intr(input string tag, input logic exp);
    exp_q.push_back(W'(exp));
    check(tag, W'(intr), exp_q.pop_front());
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    iobus_addr = addr;
    iobus_out  = data;
    iobus_wr   = 1'b1;
    tick();
    iobus_wr   = 1'b0;
    iobus_addr = 32'h0;
    iobus_out  = 32'h0;
  endtask

  initial begin
    rst        = 1'b1;
    btn_raw    = '0;
    iobus_addr = 32'h0;
    iobus_out  = 32'h0;
    iobus_wr   = 1'b0;

    // Reset
    ticks(2);
    rst = 1'b0;
    exp_read("rst_state", A_ST, 32'h0);
    exp_read("rst_event", A_EV, 32'h0);
    exp_read("rst_mask",  A_MK, 32'h0);
    exp_intr("rst_intr", 1'b0);
    iobus_addr = 32'h11008000;
    #1;
    check("unmapped_sel", W'(iobus_sel), W'(0));
    check("unmapped_rd", iobus_rd_data, 32'h0);
    iobus_addr = 32'h0;

    // Clean press on btn0: accepted on the 6th edge after it is applied
    btn_raw = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_read("press_state_pre", A_ST, 32'h0);
    end
    tick();
    exp_read("press_state", A_ST, 32'h1);
    exp_read("press_event", A_EV, 32'h1);
    ticks(2);
    exp_intr("press_intr_unmasked", 1'b0);

    // Writes to STATE and to an unmapped address change nothing
    bus_write(A_ST, 32'h0);
    bus_write(BASE + 32'hC, 32'h1F);
    exp_read("ro_state", A_ST, 32'h1);
    exp_read("ro_event", A_EV, 32'h1);
    exp_read("ro_mask",  A_MK, 32'h0);

    // Clear, release, no event on release
    bus_write(A_EV, 32'h1);
    exp_read("w1c_event", A_EV, 32'h0);
    btn_raw = '0;
    ticks(8);
    exp_read("release_state", A_ST, 32'h0);
    exp_read("release_event", A_EV, 32'h0);

    // Bounce rejection on btn2
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        btn_raw = (c < 3) ? 5'b00100 : 5'b00000;
        tick();
        exp_read("bounce_state", A_ST, 32'h0);
        exp_read("bounce_event", A_EV, 32'h0);
      end
    end
    btn_raw = '0;
    ticks(8);
    exp_read("bounce_state_end", A_ST, 32'h0);
    exp_read("bounce_event_end", A_EV, 32'h0);

    // Interrupt flow on btn0
    bus_write(A_MK, 32'hFFFF_FFE1);
    exp_read("mask_wr", A_MK, 32'h01);
    exp_intr("mask_intr", 1'b0);
    btn_raw = 5'b00001;
    ticks(6);
    exp_read("irq_event", A_EV, 32'h1);
    exp_intr("irq_intr_same_edge", 1'b0);
    tick();
    exp_intr("irq_intr", 1'b1);
    bus_write(A_EV, 32'h1);
    exp_read("irq_w1c_event", A_EV, 32'h0);
    exp_intr("irq_intr_hold", 1'b1);
    tick();
    exp_intr("irq_intr_clear", 1'b0);
    btn_raw = '0;
    ticks(8);
    exp_read("irq_release_event", A_EV, 32'h0);
    exp_intr("irq_release_intr", 1'b0);

    // Set beats clear on btn1 (masked out, so no interrupt)
    btn_raw = 5'b00010;
    ticks(5);
    exp_read("sbc_event_pre", A_EV, 32'h0);
    bus_write(A_EV, 32'h2);
    exp_read("sbc_state", A_ST, 32'h2);
    exp_read("sbc_event", A_EV, 32'h2);
    tick();
    exp_intr("sbc_intr_masked", 1'b0);
    bus_write(A_EV, 32'h2);
    exp_read("sbc_w1c", A_EV, 32'h0);
    btn_raw = '0;
    ticks(8);

    // Reset mid-debounce on btn3
    btn_raw = 5'b01000;
    ticks(2);
    exp_read("rmd_event_pre", A_EV, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_read("rmd_state_rst", A_ST, 32'h0);
    exp_read("rmd_event_rst", A_EV, 32'h0);
    exp_read("rmd_mask_rst",  A_MK, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_read("rmd_state_pre", A_ST, 32'h0);
    end
    tick();
    exp_read("rmd_state", A_ST, 32'h08);
    exp_read("rmd_event", A_EV, 32'h08);
    exp_intr("rmd_intr", 1'b0);

    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
